mem_store_buffer: RTL

- Load/store front end between the EX/MEM pipeline register and the data memory.
- Converts sb/sh/sw requests into word address, byte enables and lane-replicated write data, then queues them in a small FIFO.
- Drains the FIFO into data memory one word per cycle.
- Serves loads directly from data memory (stalling on same-word hazards) and returns sign/zero-extended load data one cycle later.

---
 rtl/mem_store_buffer.sv | 97 +++++++++
 1 files changed

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: load/store front end that encodes stores into a small FIFO
// drained one word per cycle, and serves loads directly from data memory.
module mem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_type,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_be,
   output logic        dm_we,
   output logic        dm_re,
   input  logic [31:0] dm_rdata,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   output logic        align_err,
   output logic        sb_empty
);
   logic [29:0]      e_addr [DEPTH];
   logic [3:0]       e_be   [DEPTH];
   logic [31:0]      e_data [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, off;
   logic [PTR_W:0]   count;
   logic             aligned, hazard, st_acc, ld_acc, drain;
   logic [3:0]       st_be;
   logic [31:0]      st_data, ld_ext;
   logic [7:0]       ld_b;
   logic [15:0]      ld_h;

   always_comb aligned = (req_type == 2'b10) | (req_type == 2'b01 ? !req_addr[0] : req_addr[1:0] == 2'b00);

   // an entry is live when its distance from the read pointer is below count
   always_comb begin
      hazard = 1'b0;
      off = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PTR_W'(i) - rd_ptr;
         if ({1'b0, off} < count && e_addr[i] == req_addr[31:2]) hazard = 1'b1;
      end
   end

   always_comb begin
      st_acc    = req_valid & req_write & aligned & (count != (PTR_W+1)'(DEPTH));
      ld_acc    = req_valid & !req_write & aligned & !hazard;
      req_ready = req_valid & (!aligned | st_acc | ld_acc);
      drain     = (count != '0) & !ld_acc;
      dm_we     = drain;
      dm_re     = ld_acc;
      dm_addr   = ld_acc ? req_addr : drain ? {e_addr[rd_ptr], 2'b00} : 32'd0;
      dm_be     = drain ? e_be[rd_ptr] : 4'd0;
      dm_wdata  = drain ? e_data[rd_ptr] : 32'd0;
      sb_empty  = count == '0;
   end

   always_comb begin
      st_be   = req_type == 2'b10 ? 4'b0001 << req_addr[1:0] :
                req_type == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      st_data = req_type == 2'b10 ? {4{req_wdata[7:0]}} :
                req_type == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
      ld_b    = 8'(dm_rdata >> {req_addr[1:0], 3'b000});
      ld_h    = req_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      ld_ext  = req_type == 2'b10 ? {{24{ld_b[7] & !req_unsigned}}, ld_b} :
                req_type == 2'b01 ? {{16{ld_h[15] & !req_unsigned}}, ld_h} : dm_rdata;
   end

   always_ff @(posedge clk)
      if (st_acc) begin
         e_addr[wr_ptr] <= req_addr[31:2];
         e_be[wr_ptr]   <= st_be;
         e_data[wr_ptr] <= st_data;
      end

   always_ff @(posedge clk)
      if (reset) begin
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ld_valid  <= 1'b0;
         ld_data   <= 32'd0;
         align_err <= 1'b0;
      end else begin
         if (st_acc) wr_ptr <= wr_ptr + 1'b1;
         if (drain) rd_ptr <= rd_ptr + 1'b1;
         count     <= count + (PTR_W+1)'(st_acc) - (PTR_W+1)'(drain);
         ld_valid  <= ld_acc;
         if (ld_acc) ld_data <= ld_ext;
         align_err <= req_valid & !aligned;
      end
endmodule
